wb_arbiter: RTL

- Writeback stage directly upstream of the register file.
- Merges two result sources into the register file's single write port:
  - ALU results, buffered in a small FIFO.
  - Data-memory load returns, which have priority.
- Keeps a per-register pending-load scoreboard so the decode stage can detect load-use and WAW hazards.
- Drives the register file's write enable, write address and write data from registered outputs.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 77 +++++++
 rtl/wb_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
// Entry layout, source tags and default sizing live here.
package wb_pkg;

    localparam int PW       = 3;
    localparam int DW       = 8;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [PW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_LD,
        SRC_ALU
    } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding ALU writeback entries.
// Full has no bypass: a pop never reopens a full FIFO in the same cycle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                din,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage: write the tail slot on an accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges load returns and queued ALU results
// into one register-file write port, and tracks pending loads.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int pw    = PW,
    parameter int dw    = DW,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [pw-1:0]            alu_addr,
    input  logic [dw-1:0]            alu_data,
    output logic                     alu_ready,
    input  logic                     ld_issue,
    input  logic [pw-1:0]            ld_issue_addr,
    input  logic                     ld_valid,
    input  logic [pw-1:0]            ld_addr,
    input  logic [dw-1:0]            ld_data,
    output logic                     wr_en,
    output logic [pw-1:0]            wr_addr,
    output logic [dw-1:0]            wr_dat,
    output logic [2**pw-1:0]         pend,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     err
);

    localparam int NREG = 2**pw;

    wb_entry_t        w_din;
    wb_entry_t        w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    logic             w_nxt_en;
    logic [pw-1:0]    w_nxt_addr;
    logic [dw-1:0]    w_nxt_dat;
    wb_src_t          w_nxt_src;

    logic [NREG-1:0]  w_set;
    logic [NREG-1:0]  w_clr;
    logic             w_err_ld;
    logic             w_err_iss;
    logic             w_err_alu;

    logic             r_wr_en;
    logic [pw-1:0]    r_wr_addr;
    logic [dw-1:0]    r_wr_dat;
    wb_src_t          r_src;
    logic [NREG-1:0]  r_pend;
    logic             r_err;

    assign alu_ready = !w_full;
    assign w_push    = alu_valid && alu_ready;
    assign w_pop     = !ld_valid && !w_empty;

    // Pack the incoming ALU result into a FIFO entry
    always_comb begin
        w_din      = '0;
        w_din.addr = alu_addr;
        w_din.data = alu_data;
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (q_count)
    );

    // Source select: loads win, else drain the FIFO head, else hold
    always_comb begin
        w_nxt_en   = 1'b0;
        w_nxt_addr = r_wr_addr;
        w_nxt_dat  = r_wr_dat;
        w_nxt_src  = SRC_NONE;
        unique case (1'b1)
            ld_valid: begin
                w_nxt_en   = 1'b1;
                w_nxt_addr = ld_addr;
                w_nxt_dat  = ld_data;
                w_nxt_src  = SRC_LD;
            end
            w_pop: begin
                w_nxt_en   = 1'b1;
                w_nxt_addr = w_head.addr;
                w_nxt_dat  = w_head.data;
                w_nxt_src  = SRC_ALU;
            end
            default: begin
                w_nxt_en   = 1'b0;
            end
        endcase
    end

    // Register-file write port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_dat  <= '0;
            r_src     <= SRC_NONE;
        end else begin
            r_wr_en   <= w_nxt_en;
            r_wr_addr <= w_nxt_addr;
            r_wr_dat  <= w_nxt_dat;
            r_src     <= w_nxt_src;
        end
    end

    // One-hot set/clear vectors for the pending-load scoreboard
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (ld_issue) begin
            w_set[ld_issue_addr] = 1'b1;
        end
        if (ld_valid) begin
            w_clr[ld_addr] = 1'b1;
        end
    end

    // Scoreboard update: a same-cycle set beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    // Protocol violation detection
    always_comb begin
        w_err_ld  = ld_valid && !r_pend[ld_addr];
        w_err_iss = ld_issue && r_pend[ld_issue_addr]
                    && !(ld_valid && (ld_addr == ld_issue_addr));
        w_err_alu = w_push && r_pend[alu_addr];
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_ld || w_err_iss || w_err_alu) begin
            r_err <= 1'b1;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_dat  = r_wr_dat;
    assign pend    = r_pend;
    assign err     = r_err;

    a_src_tag: assert property (
        @(posedge clk) disable iff (!rst_n)
        r_wr_en == (r_src != SRC_NONE)
    );

    a_no_full_push: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(w_full && w_push)
    );

endmodule
